// File: rtl/eth_frame_gen_if.sv
// rtl/eth_frame_gen_if.sv - GMII transmit-side byte stream bundle
//
// Purpose: carries the generated GMII transmit stream out of eth_frame_gen.
// Signals:
//   gmii_txd    8  data byte, one per clk125 cycle
//   gmii_tx_en  1  frame valid, preamble through FCS
//   gmii_tx_er  1  transmit error, held low by the generator
// Modports: master = driving side (generator), slave = observing side.
interface eth_frame_gen_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    modport master (output gmii_txd, gmii_tx_en, gmii_tx_er);
    modport slave  (input  gmii_txd, gmii_tx_en, gmii_tx_er);
endinterface

// File: rtl/eth_frame_gen.sv
// rtl/eth_frame_gen.sv - GMII Ethernet frame generator for MAC/PHY self-test
//
// Purpose: emits complete Ethernet frames one byte per clk125 cycle:
//   preamble, SFD, DST, SRC, EtherType, payload, zero pad, CRC32 FCS, IFG.
// Ports:
//   clk125, reset            clock and synchronous active-high reset
//   start, stop              run control pulses
//   frames                   frames per run, 0 = run until stop
//   dst_mac, src_mac         MAC addresses, most significant byte sent first
//   ethertype                type/length, most significant byte sent first
//   payload_len, mode, seed  payload length and pattern selection
//   corrupt_fcs              invert the first FCS byte
//   gmii                     GMII transmit stream (master modport)
//   busy, done, frame_cnt    run status
module eth_frame_gen #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int MIN_PAYLOAD  = 46
) (
    input  logic                   clk125,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            frames,
    input  logic [47:0]            dst_mac,
    input  logic [47:0]            src_mac,
    input  logic [15:0]            ethertype,
    input  logic [10:0]            payload_len,
    input  logic [1:0]             mode,
    input  logic [7:0]             seed,
    input  logic                   corrupt_fcs,
    eth_frame_gen_if.master        gmii,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            frame_cnt
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [10:0] MAX_L    = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_L    = 11'(MIN_PAYLOAD);

    // Reflected IEEE 802.3 CRC32, one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  pat_q, pat_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        done_q, done_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] type_q, type_d, frames_q, frames_d;
    logic [10:0] len_q, len_d, pad_q, pad_d;
    logic [1:0]  mode_q, mode_d;
    logic        corrupt_q, corrupt_d;

    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        crc_en;
    logic        load;
    logic        stop_now;
    logic [2:0]  byte_sel;
    logic [31:0] fcs_word;
    logic [7:0]  pat_next;
    logic [10:0] len_clamp;

    always_ff @(posedge clk125) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            crc_q       <= '1;
            pat_q       <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            frames_q    <= '0;
            len_q       <= '0;
            pad_q       <= '0;
            mode_q      <= '0;
            corrupt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            frames_q    <= frames_d;
            len_q       <= len_d;
            pad_q       <= pad_d;
            mode_q      <= mode_d;
            corrupt_q   <= corrupt_d;
        end
    end

    always_comb begin
        byte_sel  = 3'd5 - cnt_q[2:0];
        fcs_word  = ~crc_q;
        len_clamp = (payload_len > MAX_L) ? MAX_L : payload_len;
        case (mode_q)
            2'd1:    pat_next = pat_q;
            2'd2:    pat_next = lfsr_step(pat_q);
            default: pat_next = pat_q + 8'd1;
        endcase

        // Byte on the wire for the current state.
        tx_byte = 8'h00;
        tx_en   = 1'b0;
        crc_en  = 1'b0;
        case (state_q)
            S_PRE:  begin tx_byte = 8'h55; tx_en = 1'b1; end
            S_SFD:  begin tx_byte = 8'hD5; tx_en = 1'b1; end
            S_DST:  begin tx_byte = dst_q[{byte_sel, 3'b000} +: 8]; tx_en = 1'b1; crc_en = 1'b1; end
            S_SRC:  begin tx_byte = src_q[{byte_sel, 3'b000} +: 8]; tx_en = 1'b1; crc_en = 1'b1; end
            S_TYPE: begin tx_byte = cnt_q[0] ? type_q[7:0] : type_q[15:8]; tx_en = 1'b1; crc_en = 1'b1; end
            S_PAY:  begin tx_byte = pat_q; tx_en = 1'b1; crc_en = 1'b1; end
            S_PAD:  begin tx_byte = 8'h00; tx_en = 1'b1; crc_en = 1'b1; end
            S_FCS: begin
                tx_en = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    tx_byte = fcs_word[7:0] ^ {8{corrupt_q}};
                    2'd1:    tx_byte = fcs_word[15:8];
                    2'd2:    tx_byte = fcs_word[23:16];
                    default: tx_byte = fcs_word[31:24];
                endcase
            end
            default: ;
        endcase

        state_d     = state_q;
        cnt_d       = cnt_q + 11'd1;
        crc_d       = crc_en ? crc32_byte(crc_q, tx_byte) : crc_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        load        = 1'b0;
        // A stop seen in IDLE is dropped unless it coincides with an accepted start.
        stop_pend_d = stop_pend_q | (stop & ((state_q != S_IDLE) | start));
        stop_now    = stop_pend_q | stop;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        frames_d    = frames_q;
        len_d       = len_q;
        pad_d       = pad_q;
        mode_d      = mode_q;
        corrupt_d   = corrupt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    load        = 1'b1;
                    frame_cnt_d = '0;
                    state_d     = S_PRE;
                end
            end
            S_PRE:  if (cnt_q == PRE_LAST) begin state_d = S_SFD; cnt_d = '0; end
            S_SFD:  begin state_d = S_DST; cnt_d = '0; end
            S_DST:  if (cnt_q == 11'd5) begin state_d = S_SRC; cnt_d = '0; end
            S_SRC:  if (cnt_q == 11'd5) begin state_d = S_TYPE; cnt_d = '0; end
            S_TYPE: if (cnt_q == 11'd1) begin
                cnt_d   = '0;
                state_d = (len_q != 11'd0) ? S_PAY : ((pad_q != 11'd0) ? S_PAD : S_FCS);
            end
            S_PAY: begin
                // Pad bytes never advance the pattern, so only PAY steps it.
                pat_d = pat_next;
                if (cnt_q == len_q - 11'd1) begin
                    cnt_d   = '0;
                    state_d = (pad_q != 11'd0) ? S_PAD : S_FCS;
                end
            end
            S_PAD:  if (cnt_q == pad_q - 11'd1) begin state_d = S_FCS; cnt_d = '0; end
            S_FCS:  if (cnt_q == 11'd3) begin
                state_d = S_IFG;
                cnt_d   = '0;
                if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            end
            S_IFG:  if (cnt_q == IFG_LAST) begin
                if (stop_now || (frames_q != 16'd0 && frame_cnt_q >= frames_q)) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else begin
                    load    = 1'b1;
                    state_d = S_PRE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Configuration is captured once per frame on entry to PRE.
        if (load) begin
            cnt_d     = '0;
            crc_d     = '1;
            dst_d     = dst_mac;
            src_d     = src_mac;
            type_d    = ethertype;
            frames_d  = frames;
            len_d     = len_clamp;
            pad_d     = (len_clamp < MIN_L) ? (MIN_L - len_clamp) : 11'd0;
            mode_d    = mode;
            corrupt_d = corrupt_fcs;
            pat_d     = (mode == 2'd2 && seed == 8'h00) ? 8'hFF : seed;
        end
    end

    assign gmii.gmii_txd   = tx_byte;
    assign gmii.gmii_tx_en = tx_en;
    assign gmii.gmii_tx_er = 1'b0;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign frame_cnt       = frame_cnt_q;
endmodule

// File: tb/tb_eth_frame_gen.sv
// tb/tb_eth_frame_gen.sv - self-checking bench for eth_frame_gen
module tb_eth_frame_gen;
    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MAXP = 1500;
    localparam int MINP = 46;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic        clk = 1'b0;
    logic        reset, start, stop, corrupt_fcs;
    logic [15:0] frames, ethertype;
    logic [47:0] dst_mac, src_mac;
    logic [10:0] payload_len;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic        busy, done;
    logic [15:0] frame_cnt;

    eth_frame_gen_if itf ();

    eth_frame_gen dut (
        .clk125(clk), .reset(reset), .start(start), .stop(stop), .frames(frames),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .payload_len(payload_len), .mode(mode), .seed(seed), .corrupt_fcs(corrupt_fcs),
        .gmii(itf), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [15:0] frames;
        logic [10:0] len;
        logic [1:0]  mode;
        logic [7:0]  seed;
        logic        corrupt;
        int          exp_cycles;
        int          exp_good;
        int          exp_bad;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] m_crc;
    int cyc = 0, idx = 0, tx_cycles = 0, byte_err = 0, good = 0, bad = 0;
    int n_starts = 0, fall_cyc = 0, gap_n = 0, gap_bad = 0, done_cnt = 0, done_bad = 0;
    logic prev_en = 1'b0, valid_fall = 1'b0;
    logic [31:0] rx_crc = '1;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Observe the GMII stream once per cycle, away from the active edge.
    task automatic sample();
        logic [7:0] e;
        cyc++;
        if (itf.gmii_tx_er !== 1'b0) byte_err++;
        if (itf.gmii_tx_en === 1'b1) begin
            if (!prev_en) begin
                idx = 0;
                rx_crc = '1;
                n_starts++;
                if (valid_fall) begin
                    gap_n++;
                    if (cyc - fall_cyc != IFG) gap_bad++;
                end
            end
            tx_cycles++;
            if (exp_q.size() == 0) byte_err++;
            else begin
                e = exp_q.pop_front();
                if (e !== itf.gmii_txd) byte_err++;
            end
            if (idx >= PRE + 1) rx_crc = crc_byte(rx_crc, itf.gmii_txd);
            idx++;
        end else begin
            if (itf.gmii_txd !== 8'h00) byte_err++;
            if (prev_en) begin
                fall_cyc = cyc;
                valid_fall = 1'b1;
                if (rx_crc == RESIDUE) good++; else bad++;
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (!(valid_fall && cyc - fall_cyc == IFG)) done_bad++;
            valid_fall = 1'b0;
        end
        prev_en = itf.gmii_tx_en;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    task automatic push_c(input logic [7:0] b);
        exp_q.push_back(b);
        m_crc = crc_byte(m_crc, b);
    endtask

    // Reference frame built from the current configuration inputs.
    task automatic push_frame();
        int L, P;
        logic [7:0] p;
        logic [31:0] f;
        L = (payload_len > 11'(MAXP)) ? MAXP : int'(payload_len);
        P = (L < MINP) ? MINP - L : 0;
        repeat (PRE) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        m_crc = '1;
        for (int i = 0; i < 6; i++) push_c(dst_mac[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) push_c(src_mac[47 - 8*i -: 8]);
        push_c(ethertype[15:8]);
        push_c(ethertype[7:0]);
        p = (mode == 2'd2 && seed == 8'h00) ? 8'hFF : seed;
        for (int i = 0; i < L; i++) begin
            case (mode)
                2'd1:    push_c(seed);
                2'd2: begin
                    push_c(p);
                    p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
                end
                default: push_c(seed + 8'(i));
            endcase
        end
        for (int i = 0; i < P; i++) push_c(8'h00);
        f = ~m_crc;
        exp_q.push_back(f[7:0] ^ {8{corrupt_fcs}});
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[31:24]);
    endtask

    task automatic wait_done(input string nm, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 20000) begin
            step();
            n++;
        end
        check({nm, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int t0, g0, b0, e0, d0, gn0, gb0, db0;
        frames = v.frames; payload_len = v.len; mode = v.mode;
        seed = v.seed; corrupt_fcs = v.corrupt;
        stop = 1'b1; step(); stop = 1'b0; step();   // stop in IDLE is ignored
        for (int f = 0; f < int'(v.frames); f++) push_frame();
        t0 = tx_cycles; g0 = good; b0 = bad; e0 = byte_err; d0 = done_cnt;
        gn0 = gap_n; gb0 = gap_bad; db0 = done_bad;
        start = 1'b1;
        step();
        start = 1'b0;
        check({nm, "_latency"}, {54'd0, itf.gmii_tx_en, itf.gmii_txd, busy}, {54'd0, 1'b1, 8'h55, 1'b1});
        repeat (5) step();
        start = 1'b1; step(); start = 1'b0;          // start while busy is ignored
        wait_done(nm, d0);
        repeat (3) step();
        check({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({nm, "_tx_cycles"}, 64'(tx_cycles - t0), 64'(v.exp_cycles));
        check({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(v.frames));
        check({nm, "_crc_good"}, 64'(good - g0), 64'(v.exp_good));
        check({nm, "_crc_bad"}, 64'(bad - b0), 64'(v.exp_bad));
        check({nm, "_byte_err"}, 64'(byte_err - e0), 64'd0);
        check({nm, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_gaps"}, 64'(gap_n - gn0), 64'(int'(v.frames) - 1));
        check({nm, "_gap_len"}, 64'(gap_bad - gb0), 64'd0);
        check({nm, "_done_delay"}, 64'(done_bad - db0), 64'd0);
        check({nm, "_busy_end"}, 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int d0, e0, g0, b0, t0, s0, n;
        vecs[0] = '{16'd1, 11'd60,   2'd0, 8'h00, 1'b0, 86,   1, 0};
        vecs[1] = '{16'd1, 11'd10,   2'd1, 8'hA5, 1'b0, 72,   1, 0};
        vecs[2] = '{16'd3, 11'd2000, 2'd0, 8'h33, 1'b0, 4578, 3, 0};
        vecs[3] = '{16'd1, 11'd0,    2'd3, 8'h7E, 1'b1, 72,   0, 1};
        vecs[4] = '{16'd2, 11'd46,   2'd2, 8'h00, 1'b0, 144,  2, 0};
        vecs[5] = '{16'd1, 11'd45,   2'd2, 8'h3C, 1'b0, 72,   1, 0};
        vecs[6] = '{16'd1, 11'd1500, 2'd0, 8'hF0, 1'b0, 1526, 1, 0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; corrupt_fcs = 1'b0;
        frames = 16'd1; payload_len = 11'd60; mode = 2'd0; seed = 8'h00;
        dst_mac = 48'h0102_0304_0506; src_mac = 48'hA1B2_C3D4_E5F6; ethertype = 16'h88B5;
        repeat (3) step();
        check("reset_outputs", {50'd0, itf.gmii_txd, itf.gmii_tx_en, itf.gmii_tx_er, busy, done},
              64'd0);
        check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Continuous run with LFSR payload, stop raised in the middle of frame 2.
        frames = 16'd0; payload_len = 11'd20; mode = 2'd2; seed = 8'h00; corrupt_fcs = 1'b0;
        push_frame(); push_frame();
        d0 = done_cnt; e0 = byte_err; g0 = good; b0 = bad; t0 = tx_cycles; s0 = n_starts;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while ((n_starts - s0 < 2 || idx < 30) && n < 2000) begin step(); n++; end
        check("cont_reach_frame2", 64'(n < 2000), 64'd1);
        stop = 1'b1; step(); stop = 1'b0;
        wait_done("cont", d0);
        check("cont_frame_cnt", 64'(frame_cnt), 64'd2);
        check("cont_crc_good", 64'(good - g0), 64'd2);
        check("cont_crc_bad", 64'(bad - b0), 64'd0);
        check("cont_tx_cycles", 64'(tx_cycles - t0), 64'd144);
        check("cont_byte_err", 64'(byte_err - e0), 64'd0);
        check("cont_exp_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) step();

        // start and stop together in IDLE: one frame, then IDLE.
        payload_len = 11'd5; mode = 2'd0; seed = 8'h80;
        push_frame();
        d0 = done_cnt; e0 = byte_err; t0 = tx_cycles;
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        wait_done("startstop", d0);
        check("startstop_frame_cnt", 64'(frame_cnt), 64'd1);
        check("startstop_tx_cycles", 64'(tx_cycles - t0), 64'd72);
        check("startstop_byte_err", 64'(byte_err - e0), 64'd0);
        exp_q.delete();
        repeat (3) step();

        // Reset in the middle of the payload.
        frames = 16'd1; payload_len = 11'd100; mode = 2'd0; seed = 8'h10;
        push_frame();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (idx < 40 && n < 500) begin step(); n++; end
        check("rst_reach_pay", 64'(itf.gmii_tx_en), 64'd1);
        reset = 1'b1; step();
        check("rst_tx_en", 64'(itf.gmii_tx_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        reset = 1'b0;
        valid_fall = 1'b0;
        exp_q.delete();
        step();
        run_vec("after_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
